// File: rtl/systolic_result_collector.sv
// Ping-pong result buffer behind the systolic array: captures N_SIZE result rows per
// product, restores natural column order and drains each matrix row-major over valid/ready.
module systolic_result_collector #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            c_valid_in,
  input  logic signed [2*DATAWIDTH-1:0]   matrix_c_in [N_SIZE],
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic signed [2*DATAWIDTH-1:0]   m_data,
  output logic [$clog2(N_SIZE)-1:0]       m_row,
  output logic [$clog2(N_SIZE)-1:0]       m_col,
  output logic                            m_last,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int W  = 2 * DATAWIDTH;
  localparam int AW = $clog2(N_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_SIZE - 1);

  logic signed [W-1:0] buffer [2][N_SIZE][N_SIZE];
  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [AW-1:0]       wr_row;
  logic [AW-1:0]       rd_row;
  logic [AW-1:0]       rd_col;
  logic                drop;

  logic handshake;
  logic free_evt;
  logic row0;
  logic accept;
  logic write_en;
  logic reject;

  assign m_valid = full[rd_bank];
  assign m_data  = buffer[rd_bank][rd_row][rd_col];
  assign m_row   = rd_row;
  assign m_col   = rd_col;
  assign m_last  = m_valid && (rd_row == LAST_IDX) && (rd_col == LAST_IDX);

  assign handshake = m_valid & m_ready;
  assign free_evt  = handshake & m_last;
  assign row0      = (wr_row == '0);
  // A bank being released by the final handshake this cycle counts as free.
  assign accept    = !full[wr_bank] || (free_evt && (rd_bank == wr_bank));
  assign write_en  = c_valid_in && (row0 ? accept : !drop);
  assign reject    = c_valid_in && row0 && !accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < N_SIZE; r++)
          for (int c = 0; c < N_SIZE; c++)
            buffer[b][r][c] <= '0;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_row   <= '0;
      rd_row   <= '0;
      rd_col   <= '0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // The array emits columns reversed; element [j] belongs in column N_SIZE-1-j.
      if (write_en)
        for (int k = 0; k < N_SIZE; k++)
          buffer[wr_bank][wr_row][k] <= matrix_c_in[N_SIZE-1-k];

      if (handshake) begin
        if (rd_col == LAST_IDX) begin
          rd_col <= '0;
          if (rd_row == LAST_IDX) begin
            rd_row        <= '0;
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
          end else begin
            rd_row <= rd_row + 1'b1;
          end
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end

      if (c_valid_in) begin
        if (reject)
          drop <= 1'b1;
        if (wr_row == LAST_IDX) begin
          wr_row <= '0;
          drop   <= 1'b0;
          if (write_en) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
          end
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end

      if (reject)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

endmodule
